// File: rtl/segment_transition_ctl.sv
// segment_transition_ctl
// Owns the active-segment register for NUM_SEGMENTS sample buffers. A host
// request is either applied at once or parked until its trigger fires (loop
// end, system time, or a GPIO rising edge). Loop repetitions are counted per
// segment, and STOP is raised once the repetition budget is used up.
module segment_transition_ctl #(
  parameter int NUM_SEGMENTS = 2,
  parameter int IDX_WIDTH    = 15,
  localparam int SEG_W       = (NUM_SEGMENTS > 2) ? $clog2(NUM_SEGMENTS) : 1
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic                                  UPDATE,
  input  logic [SEG_W-1:0]                      REQ_RD_SEGMENT,
  input  logic [7:0]                            TRANSITION_MODE,
  input  logic [63:0]                           TRANSITION_VALUE,
  input  logic [NUM_SEGMENTS-1:0][IDX_WIDTH-1:0] CYCLE,
  input  logic [NUM_SEGMENTS-1:0][15:0]         REP,
  input  logic [IDX_WIDTH-1:0]                  IDX,
  input  logic                                  IDX_VALID,
  input  logic [63:0]                           SYS_TIME,
  input  logic [3:0]                            GPIO_IN,
  output logic [SEG_W-1:0]                      SEGMENT,
  output logic                                  SWAP,
  output logic                                  STOP,
  output logic                                  PENDING,
  output logic                                  ERR
);

  localparam logic [7:0]   MODE_SYNC_IDX  = 8'h00;
  localparam logic [7:0]   MODE_SYS_TIME  = 8'h01;
  localparam logic [7:0]   MODE_GPIO      = 8'h02;
  localparam logic [7:0]   MODE_IMMEDIATE = 8'hFF;
  localparam logic [15:0]  REP_INFINITE   = 16'hFFFF;
  localparam logic [15:0]  CNT_SATURATE   = 16'hFFFE;
  localparam logic [SEG_W:0] SEG_LIMIT    = (SEG_W + 1)'(NUM_SEGMENTS);

  typedef enum logic {
    ST_RUN,
    ST_WAIT
  } state_t;

  state_t            state_reg, state_next;
  logic [SEG_W-1:0]  pend_seg_reg, pend_seg_next;
  logic [7:0]        pend_mode_reg, pend_mode_next;
  logic [63:0]       pend_value_reg, pend_value_next;
  logic [SEG_W-1:0]  seg_reg, seg_next;
  logic              swap_reg, swap_next;
  logic              stop_reg, stop_next;
  logic              err_reg, err_next;
  logic [15:0]       loop_cnt_reg, loop_cnt_next;

  logic [3:0]        gpio_meta_reg;
  logic [3:0]        gpio_sync_reg;
  logic [3:0]        gpio_prev_reg;
  logic [3:0]        gpio_rise;

  logic              loop_end;
  logic [15:0]       rep_cur;
  logic              rep_inf;
  logic              mode_known;
  logic              req_ok;
  logic              pend_trigger;
  logic              do_switch;
  logic [SEG_W-1:0]  switch_seg;

  // Two-flop synchroniser for the asynchronous pins, plus a delayed copy for edge detection
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gpio_meta_reg <= '0;
      gpio_sync_reg <= '0;
      gpio_prev_reg <= '0;
    end else begin
      gpio_meta_reg <= GPIO_IN;
      gpio_sync_reg <= gpio_meta_reg;
      gpio_prev_reg <= gpio_sync_reg;
    end
  end

  assign gpio_rise  = gpio_sync_reg & ~gpio_prev_reg;
  assign loop_end   = IDX_VALID && (IDX == CYCLE[seg_reg]);
  assign rep_cur    = REP[seg_reg];
  assign rep_inf    = (rep_cur == REP_INFINITE);
  assign mode_known = (TRANSITION_MODE == MODE_SYNC_IDX) || (TRANSITION_MODE == MODE_SYS_TIME) ||
                      (TRANSITION_MODE == MODE_GPIO)     || (TRANSITION_MODE == MODE_IMMEDIATE);
  assign req_ok     = ({1'b0, REQ_RD_SEGMENT} < SEG_LIMIT) && mode_known;

  // Trigger condition of the parked request; a stopped segment has no loop end left to wait for
  always_comb begin
    pend_trigger = 1'b0;
    case (pend_mode_reg)
      MODE_SYNC_IDX: pend_trigger = loop_end || stop_reg;
      MODE_SYS_TIME: pend_trigger = (SYS_TIME >= pend_value_reg);
      MODE_GPIO:     pend_trigger = gpio_rise[pend_value_reg[1:0]];
      default:       pend_trigger = 1'b0;
    endcase
  end

  // Request acceptance, switch decision and repetition counting
  always_comb begin
    state_next      = state_reg;
    pend_seg_next   = pend_seg_reg;
    pend_mode_next  = pend_mode_reg;
    pend_value_next = pend_value_reg;
    seg_next        = seg_reg;
    swap_next       = 1'b0;
    stop_next       = stop_reg;
    err_next        = 1'b0;
    loop_cnt_next   = loop_cnt_reg;
    do_switch       = 1'b0;
    switch_seg      = pend_seg_reg;

    if (UPDATE) begin
      if (!req_ok) begin
        // Rejected: the existing request (if any) stays as it is
        err_next = 1'b1;
      end else if (TRANSITION_MODE == MODE_IMMEDIATE) begin
        do_switch  = 1'b1;
        switch_seg = REQ_RD_SEGMENT;
      end else begin
        state_next      = ST_WAIT;
        pend_seg_next   = REQ_RD_SEGMENT;
        pend_mode_next  = TRANSITION_MODE;
        pend_value_next = TRANSITION_VALUE;
      end
    end

    // An accepted UPDATE supersedes whatever the old request was about to do
    if (!(UPDATE && req_ok) && (state_reg == ST_WAIT) && pend_trigger) begin
      do_switch = 1'b1;
    end

    if (do_switch) begin
      // A switch absorbs any coincident loop end: fresh segment, fresh count
      seg_next      = switch_seg;
      swap_next     = 1'b1;
      loop_cnt_next = '0;
      stop_next     = 1'b0;
      state_next    = ST_RUN;
    end else if (loop_end && !stop_reg) begin
      if (!rep_inf && (loop_cnt_reg == rep_cur)) begin
        stop_next = 1'b1;
      end else if (!(rep_inf && (loop_cnt_reg == CNT_SATURATE))) begin
        loop_cnt_next = loop_cnt_reg + 16'd1;
      end
    end
  end

  // State, pending request and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg      <= ST_RUN;
      pend_seg_reg   <= '0;
      pend_mode_reg  <= '0;
      pend_value_reg <= '0;
      seg_reg        <= '0;
      swap_reg       <= 1'b0;
      stop_reg       <= 1'b0;
      err_reg        <= 1'b0;
      loop_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      pend_seg_reg   <= pend_seg_next;
      pend_mode_reg  <= pend_mode_next;
      pend_value_reg <= pend_value_next;
      seg_reg        <= seg_next;
      swap_reg       <= swap_next;
      stop_reg       <= stop_next;
      err_reg        <= err_next;
      loop_cnt_reg   <= loop_cnt_next;
    end
  end

  assign SEGMENT = seg_reg;
  assign SWAP    = swap_reg;
  assign STOP    = stop_reg;
  assign PENDING = (state_reg == ST_WAIT);
  assign ERR     = err_reg;

endmodule

// File: tb/tb_segment_transition_ctl.sv
// Testbench for segment_transition_ctl (5 segments, 15-bit index).
// Directed vector table, hand-written time/GPIO/reset sequences, then random
// stimulus compared against a request/loop-count reference model.
module tb_segment_transition_ctl;

  localparam int NSEG = 5;
  localparam int IW   = 15;
  localparam int SW   = 3;

  logic                     CLK = 1'b0;
  logic                     RST;
  logic                     UPDATE;
  logic [SW-1:0]            REQ_RD_SEGMENT;
  logic [7:0]               TRANSITION_MODE;
  logic [63:0]              TRANSITION_VALUE;
  logic [NSEG-1:0][IW-1:0]  CYCLE;
  logic [NSEG-1:0][15:0]    REP;
  logic [IW-1:0]            IDX;
  logic                     IDX_VALID;
  logic [63:0]              SYS_TIME;
  logic [3:0]               GPIO_IN;
  logic [SW-1:0]            SEGMENT;
  logic                     SWAP;
  logic                     STOP;
  logic                     PENDING;
  logic                     ERR;

  segment_transition_ctl #(
    .NUM_SEGMENTS(NSEG),
    .IDX_WIDTH(IW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .UPDATE(UPDATE),
    .REQ_RD_SEGMENT(REQ_RD_SEGMENT),
    .TRANSITION_MODE(TRANSITION_MODE),
    .TRANSITION_VALUE(TRANSITION_VALUE),
    .CYCLE(CYCLE),
    .REP(REP),
    .IDX(IDX),
    .IDX_VALID(IDX_VALID),
    .SYS_TIME(SYS_TIME),
    .GPIO_IN(GPIO_IN),
    .SEGMENT(SEGMENT),
    .SWAP(SWAP),
    .STOP(STOP),
    .PENDING(PENDING),
    .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          upd;
    logic [SW-1:0] seg;
    logic [7:0]    mode;
    logic [63:0]   val;
    logic          iv;
    logic [IW-1:0] idx;
    logic [SW-1:0] e_seg;
    logic          e_swap;
    logic          e_stop;
    logic          e_pend;
    logic          e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int u, int s, int m, longint v, int iv, int ix,
                              int es, int esw, int est, int ep, int ee);
    vec_t r;
    r.upd = 1'(u);   r.seg = SW'(s); r.mode = 8'(m); r.val = 64'(v);
    r.iv  = 1'(iv);  r.idx = IW'(ix);
    r.e_seg = SW'(es); r.e_swap = 1'(esw); r.e_stop = 1'(est);
    r.e_pend = 1'(ep); r.e_err = 1'(ee);
    return r;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic u, input logic [SW-1:0] s, input logic [7:0] m,
                       input logic [63:0] v, input logic iv, input logic [IW-1:0] ix);
    UPDATE = u; REQ_RD_SEGMENT = s; TRANSITION_MODE = m; TRANSITION_VALUE = v;
    IDX_VALID = iv; IDX = ix;
  endtask

  task automatic idle();
    drive(1'b0, '0, 8'h00, 64'd0, 1'b0, '0);
  endtask

  task automatic check_outs(input string tag, input logic [SW-1:0] e_seg, input logic e_swap,
                            input logic e_stop, input logic e_pend, input logic e_err);
    n_checks++;
    if (SEGMENT !== e_seg) begin
      n_fail++; $display("FAIL %s SEGMENT: got %0d expected %0d", tag, SEGMENT, e_seg);
    end
    n_checks++;
    if (SWAP !== e_swap) begin
      n_fail++; $display("FAIL %s SWAP: got %0b expected %0b", tag, SWAP, e_swap);
    end
    n_checks++;
    if (STOP !== e_stop) begin
      n_fail++; $display("FAIL %s STOP: got %0b expected %0b", tag, STOP, e_stop);
    end
    n_checks++;
    if (PENDING !== e_pend) begin
      n_fail++; $display("FAIL %s PENDING: got %0b expected %0b", tag, PENDING, e_pend);
    end
    n_checks++;
    if (ERR !== e_err) begin
      n_fail++; $display("FAIL %s ERR: got %0b expected %0b", tag, ERR, e_err);
    end
  endtask

  // Reference model: request bookkeeping plus "loops played" per segment.
  int          m_seg, m_pseg, m_pmode, m_plays;
  bit          m_stop, m_pend, e_swap, e_err;
  logic [63:0] m_pval;
  logic [3:0]  gq[$];   // pin values at past edges, gq[0] = most recent

  task automatic model_reset();
    m_seg = 0; m_pseg = 0; m_pmode = 0; m_plays = 0; m_stop = 0; m_pend = 0;
    m_pval = '0; e_swap = 0; e_err = 0;
    gq.delete();
    repeat (3) gq.push_front(4'b0000);
  endtask

  task automatic model_edge();
    bit le, trig, ok, sw;
    int tgt;
    int pin;
    le   = IDX_VALID && (IDX == CYCLE[m_seg]);
    pin  = int'(m_pval[1:0]);
    trig = 0;
    if (m_pend) begin
      case (m_pmode)
        0: trig = le || m_stop;
        1: trig = (SYS_TIME >= m_pval);
        2: trig = gq[1][pin] && !gq[2][pin];   // pin high two edges ago, low three ago
        default: trig = 0;
      endcase
    end
    e_swap = 0; e_err = 0; sw = 0; tgt = m_pseg;
    if (UPDATE) begin
      ok = (int'(REQ_RD_SEGMENT) < NSEG) &&
           (TRANSITION_MODE inside {8'h00, 8'h01, 8'h02, 8'hFF});
      if (!ok) begin
        e_err = 1;
      end else begin
        trig = 0;
        if (TRANSITION_MODE == 8'hFF) begin
          sw = 1; tgt = int'(REQ_RD_SEGMENT);
        end else begin
          m_pend = 1; m_pseg = int'(REQ_RD_SEGMENT);
          m_pmode = int'(TRANSITION_MODE); m_pval = TRANSITION_VALUE;
        end
      end
    end
    if (trig) sw = 1;
    if (sw) begin
      m_seg = tgt; e_swap = 1; m_plays = 0; m_stop = 0; m_pend = 0;
    end else if (le && !m_stop) begin
      m_plays++;
      if (REP[m_seg] != 16'hFFFF && m_plays > int'(REP[m_seg])) m_stop = 1;
    end
    gq.push_front(GPIO_IN);
    void'(gq.pop_back());
  endtask

  initial begin
    RST = 1'b1;
    idle();
    SYS_TIME = 64'd0;
    GPIO_IN  = 4'b0000;
    for (int s = 0; s < NSEG; s++) CYCLE[s] = IW'(3);
    REP[0] = 16'd1; REP[1] = 16'd0; REP[2] = 16'd0; REP[3] = 16'hFFFF; REP[4] = 16'd0;
    repeat (3) step();
    RST = 1'b0;
    step();
    check_outs("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // upd seg mode value iv idx | seg swap stop pend err
    vecs.push_back(mk(0,0,8'h00,0,0,0, 0,0,0,0,0));
    // segment 0 with REP=1: two passes of 0..3, then STOP; a third pass is inert
    vecs.push_back(mk(0,0,8'h00,0,1,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,8'h00,0,1,1, 0,0,0,0,0));
    vecs.push_back(mk(0,0,8'h00,0,1,2, 0,0,0,0,0));
    vecs.push_back(mk(0,0,8'h00,0,1,3, 0,0,0,0,0));
    vecs.push_back(mk(0,0,8'h00,0,1,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,8'h00,0,1,1, 0,0,0,0,0));
    vecs.push_back(mk(0,0,8'h00,0,1,2, 0,0,0,0,0));
    vecs.push_back(mk(0,0,8'h00,0,1,3, 0,0,1,0,0));
    vecs.push_back(mk(0,0,8'h00,0,1,0, 0,0,1,0,0));
    vecs.push_back(mk(0,0,8'h00,0,1,3, 0,0,1,0,0));
    // IMMEDIATE to segment 1
    vecs.push_back(mk(1,1,8'hFF,0,0,0, 1,1,0,0,0));
    vecs.push_back(mk(0,0,8'h00,0,0,0, 1,0,0,0,0));
    // SYNC_IDX to segment 2 requested at index 1; loop end of REP=0 segment is the switch
    vecs.push_back(mk(0,0,8'h00,0,1,0, 1,0,0,0,0));
    vecs.push_back(mk(1,2,8'h00,0,1,1, 1,0,0,1,0));
    vecs.push_back(mk(0,0,8'h00,0,1,2, 1,0,0,1,0));
    vecs.push_back(mk(0,0,8'h00,0,1,3, 2,1,0,0,0));
    vecs.push_back(mk(0,0,8'h00,0,0,0, 2,0,0,0,0));
    // segment 2 plays once, then SYNC_IDX while stopped switches on the next cycle
    vecs.push_back(mk(0,0,8'h00,0,1,3, 2,0,1,0,0));
    vecs.push_back(mk(1,0,8'h00,0,0,0, 2,0,1,1,0));
    vecs.push_back(mk(0,0,8'h00,0,0,0, 0,1,0,0,0));
    vecs.push_back(mk(0,0,8'h00,0,0,0, 0,0,0,0,0));
    // rejected requests: out-of-range segment, unknown mode, reject while pending
    vecs.push_back(mk(1,5,8'hFF,0,0,0, 0,0,0,0,1));
    vecs.push_back(mk(1,1,8'h07,0,0,0, 0,0,0,0,1));
    vecs.push_back(mk(0,0,8'h00,0,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,1,8'h01,-1,0,0, 0,0,0,1,0));
    vecs.push_back(mk(1,6,8'hFF,0,0,0, 0,0,0,1,1));
    vecs.push_back(mk(0,0,8'h00,0,0,0, 0,0,0,1,0));
    // replace with SYNC_IDX to 2, then IMMEDIATE to 3 in the loop-end cycle
    vecs.push_back(mk(1,2,8'h00,0,0,0, 0,0,0,1,0));
    vecs.push_back(mk(1,3,8'hFF,0,1,3, 3,1,0,0,0));
    vecs.push_back(mk(0,0,8'h00,0,1,3, 3,0,0,0,0));
    // re-request of the active segment is a full switch
    vecs.push_back(mk(1,3,8'hFF,0,0,0, 3,1,0,0,0));
    vecs.push_back(mk(0,0,8'h00,0,0,0, 3,0,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].upd, vecs[i].seg, vecs[i].mode, vecs[i].val, vecs[i].iv, vecs[i].idx);
      step();
      $display("vec %0d: upd=%0b seg=%0d mode=%02h iv=%0b idx=%0d -> SEGMENT=%0d SWAP=%0b STOP=%0b PENDING=%0b ERR=%0b",
               i, vecs[i].upd, vecs[i].seg, vecs[i].mode, vecs[i].iv, vecs[i].idx,
               SEGMENT, SWAP, STOP, PENDING, ERR);
      check_outs($sformatf("vec%0d", i), vecs[i].e_seg, vecs[i].e_swap, vecs[i].e_stop,
                 vecs[i].e_pend, vecs[i].e_err);
    end

    // SYS_TIME ramp: switch lands right after the edge that saw 1000
    SYS_TIME = 64'd990;
    drive(1'b1, 3'd1, 8'h01, 64'd1000, 1'b0, '0);
    step();
    check_outs("time_req", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    for (int t = 991; t <= 1003; t++) begin
      SYS_TIME = 64'(t);
      step();
      $display("time %0d: SEGMENT=%0d SWAP=%0b PENDING=%0b", t, SEGMENT, SWAP, PENDING);
      if (t < 1000)       check_outs($sformatf("time%0d", t), 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
      else if (t == 1000) check_outs($sformatf("time%0d", t), 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      else                check_outs($sformatf("time%0d", t), 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // SYS_TIME value already in the past
    SYS_TIME = 64'd900;
    drive(1'b1, 3'd4, 8'h01, 64'd5, 1'b0, '0);
    step();
    check_outs("past_req", 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    step();
    check_outs("past_sw", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check_outs("past_after", 3'd4, 1'b0, 1'b0, 1'b0, 1'b0);

    // GPIO request on pin 2; a glitch on pin 0 must not switch
    drive(1'b1, 3'd2, 8'h02, 64'd2, 1'b0, '0);
    step();
    check_outs("gpio_req", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    GPIO_IN = 4'b0001;
    step();
    GPIO_IN = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      check_outs($sformatf("gpio_glitch%0d", k), 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
    end
    GPIO_IN = 4'b0100;
    for (int k = 1; k <= 4; k++) begin
      step();
      $display("gpio edge %0d after rise: SEGMENT=%0d SWAP=%0b", k, SEGMENT, SWAP);
      if (k < 3)       check_outs($sformatf("gpio_e%0d", k), 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
      else if (k == 3) check_outs($sformatf("gpio_e%0d", k), 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      else             check_outs($sformatf("gpio_e%0d", k), 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    GPIO_IN = 4'b0000;

    // asynchronous reset mid-operation drops the pending request
    drive(1'b1, 3'd1, 8'h00, 64'd0, 1'b0, '0);
    step();
    check_outs("pre_rst", 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    #3;
    RST = 1'b1;
    #1;
    check_outs("async_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) step();
    RST = 1'b0;
    step();
    check_outs("post_rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // randomized phase against the reference model
    model_reset();
    for (int s = 0; s < NSEG; s++) begin
      CYCLE[s] = IW'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: REP[s] = 16'd0;
        1: REP[s] = 16'd1;
        2: REP[s] = 16'd2;
        default: REP[s] = 16'hFFFF;
      endcase
    end
    SYS_TIME = 64'd1000;
    for (int c = 0; c < 3000; c++) begin
      UPDATE         = ($urandom_range(0, 7) == 0);
      REQ_RD_SEGMENT = SW'($urandom_range(0, 5));
      case ($urandom_range(0, 5))
        0: TRANSITION_MODE = 8'hFF;
        1: TRANSITION_MODE = 8'h00;
        2: TRANSITION_MODE = 8'h01;
        3: TRANSITION_MODE = 8'h02;
        4: TRANSITION_MODE = 8'($urandom);
        default: TRANSITION_MODE = 8'h00;
      endcase
      if (TRANSITION_MODE == 8'h01)
        TRANSITION_VALUE = SYS_TIME + 64'($urandom_range(0, 40)) - 64'd8;
      else
        TRANSITION_VALUE = {$urandom, $urandom};
      IDX_VALID = 1'($urandom_range(0, 1));
      IDX       = IW'($urandom_range(0, 3));
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) GPIO_IN[b] = ~GPIO_IN[b];
      SYS_TIME = SYS_TIME + 64'd1;
      model_edge();
      step();
      if (UPDATE)
        $display("rand %0d: UPDATE seg=%0d mode=%02h -> SEGMENT=%0d PENDING=%0b ERR=%0b",
                 c, REQ_RD_SEGMENT, TRANSITION_MODE, SEGMENT, PENDING, ERR);
      check_outs($sformatf("rand%0d", c), SW'(m_seg), e_swap, m_stop, m_pend, e_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
